// File: rtl/agc_sequencer.sv
// rtl/agc_sequencer.sv - round-robin closed-loop PWM gain sequencer for RF channels 1-3
// Settles each channel, counts magnitude-bit hits over a fixed window, then nudges its gain code.
module agc_sequencer #(
  parameter int WIN_LOG2      = 12,
  parameter int SETTLE_CYCLES = 4096,
  parameter int STEP          = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       sample_en,
  input  logic [1:0] si_ch1,
  input  logic [1:0] si_ch2,
  input  logic [1:0] si_ch3,
  input  logic [7:0] thr_hi,
  input  logic [7:0] thr_lo,
  input  logic [9:0] gain_init_ch1,
  input  logic [9:0] gain_init_ch2,
  input  logic [9:0] gain_init_ch3,
  output logic [9:0] gain_ch1,
  output logic [9:0] gain_ch2,
  output logic [9:0] gain_ch3,
  output logic [1:0] chan,
  output logic       busy,
  output logic [7:0] last_frac,
  output logic       update
);

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DECIDE} state_t;

  localparam int             SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [9:0]     STEP_V      = 10'(STEP);
  localparam logic [9:0]     GAIN_MAX    = 10'd1023;

  state_t                  state_q, state_d;
  logic [SW-1:0]           settle_q, settle_d;
  logic [WIN_LOG2-1:0]     samp_q, samp_d;
  logic [WIN_LOG2:0]       mag_q, mag_d;
  logic [2:0][9:0]         gain_q, gain_d;
  logic [1:0]              chan_q, chan_d;
  logic [7:0]              last_frac_q, last_frac_d;
  logic                    update_q, update_d;

  logic                    sel_mag;
  logic [9:0]              sel_gain;
  logic [9:0]              new_gain;
  logic [WIN_LOG2+8:0]     frac_wide;
  logic [7:0]              frac;
  logic [2:0][9:0]         gain_init;
  logic                    unused_sign;

  assign gain_init   = {gain_init_ch3, gain_init_ch2, gain_init_ch1};
  assign unused_sign = ^{si_ch1[1], si_ch2[1], si_ch3[1]};

  always_comb begin
    sel_mag  = si_ch1[0];
    sel_gain = gain_q[0];
    case (chan_q)
      2'd1: begin sel_mag = si_ch2[0]; sel_gain = gain_q[1]; end
      2'd2: begin sel_mag = si_ch3[0]; sel_gain = gain_q[2]; end
      default: ;
    endcase
    // A full-window count lands on 256 and clamps to 255.
    frac_wide = {mag_q, 8'd0} >> WIN_LOG2;
    frac      = (|frac_wide[WIN_LOG2+8:8]) ? 8'hFF : frac_wide[7:0];
    if (frac > thr_hi)
      new_gain = (sel_gain < STEP_V) ? 10'd0 : sel_gain - STEP_V;
    else if (frac < thr_lo)
      new_gain = (sel_gain > GAIN_MAX - STEP_V) ? GAIN_MAX : sel_gain + STEP_V;
    else
      new_gain = sel_gain;
  end

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    samp_d      = samp_q;
    mag_d       = mag_q;
    gain_d      = gain_q;
    chan_d      = chan_q;
    last_frac_d = last_frac_q;
    update_d    = 1'b0;
    case (state_q)
      IDLE: begin
        gain_d = gain_init;
        chan_d = 2'd0;
        if (enable) begin
          state_d  = SETTLE;
          settle_d = '0;
        end
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = MEASURE;
          samp_d  = '0;
          mag_d   = '0;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      MEASURE: begin
        if (sample_en) begin
          samp_d = samp_q + WIN_LOG2'(1);
          mag_d  = mag_q + (WIN_LOG2+1)'(sel_mag);
          if (&samp_q) state_d = DECIDE;
        end
      end
      DECIDE: begin
        for (int i = 0; i < 3; i++)
          if (chan_q == 2'(i)) gain_d[i] = new_gain;
        last_frac_d = frac;
        chan_d      = (chan_q == 2'd2) ? 2'd0 : chan_q + 2'd1;
        update_d    = enable;
        state_d     = SETTLE;
        settle_d    = '0;
      end
      default: state_d = IDLE;
    endcase
    // Dropping enable aborts the visit; a DECIDE in flight still commits its gain.
    if (!enable && state_q != IDLE) begin
      state_d = IDLE;
      if (state_q != DECIDE) begin
        gain_d = gain_init;
        chan_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      samp_q      <= '0;
      mag_q       <= '0;
      gain_q      <= {3{10'd512}};
      chan_q      <= 2'd0;
      last_frac_q <= 8'd0;
      update_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      samp_q      <= samp_d;
      mag_q       <= mag_d;
      gain_q      <= gain_d;
      chan_q      <= chan_d;
      last_frac_q <= last_frac_d;
      update_q    <= update_d;
    end
  end

  assign gain_ch1  = gain_q[0];
  assign gain_ch2  = gain_q[1];
  assign gain_ch3  = gain_q[2];
  assign chan      = chan_q;
  assign busy      = (state_q != IDLE);
  assign last_frac = last_frac_q;
  assign update    = update_q;

endmodule

// File: tb/tb_agc_sequencer.sv
// tb/tb_agc_sequencer.sv - self-checking bench for agc_sequencer
// Table vectors, hand-written corner sequences and a randomized run against a visit-level model.
module tb_agc_sequencer;

  logic       clk = 1'b0;
  logic       reset, enable, sample_en;
  logic [1:0] si_ch1, si_ch2, si_ch3;
  logic [7:0] thr_hi, thr_lo;
  logic [9:0] gain_init_ch1, gain_init_ch2, gain_init_ch3;
  logic [9:0] gain_ch1, gain_ch2, gain_ch3;
  logic [1:0] chan;
  logic       busy, update;
  logic [7:0] last_frac;

  int checks = 0;
  int failures = 0;

  agc_sequencer #(.WIN_LOG2(4), .SETTLE_CYCLES(8), .STEP(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_en(sample_en),
    .si_ch1(si_ch1), .si_ch2(si_ch2), .si_ch3(si_ch3),
    .thr_hi(thr_hi), .thr_lo(thr_lo),
    .gain_init_ch1(gain_init_ch1), .gain_init_ch2(gain_init_ch2), .gain_init_ch3(gain_init_ch3),
    .gain_ch1(gain_ch1), .gain_ch2(gain_ch2), .gain_ch3(gain_ch3),
    .chan(chan), .busy(busy), .last_frac(last_frac), .update(update)
  );

  always #5 clk = ~clk;

  typedef struct {
    int init; int k; int hi; int lo; int efrac; int egain;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int gain_of(input int c);
    case (c)
      0: return int'(gain_ch1);
      1: return int'(gain_ch2);
      default: return int'(gain_ch3);
    endcase
  endfunction

  task automatic set_si(input int ch, input bit b);
    si_ch1 = 2'($urandom);
    si_ch2 = 2'($urandom);
    si_ch3 = 2'($urandom);
    case (ch)
      0: si_ch1[0] = b;
      1: si_ch2[0] = b;
      default: si_ch3[0] = b;
    endcase
  endtask

  // One channel visit: 8 settle cycles, a 16-sample window with random gaps, one DECIDE cycle.
  task automatic run_visit(input int ch, input int k, input bit drop, input bit hot,
                           output int frac_o, output int gain_o);
    bit pat[16];
    bit early = 1'b0;
    int acc = 0;
    int cyc = 0;
    for (int i = 0; i < 16; i++) pat[i] = (i < k);
    for (int i = 0; i < 16; i++) begin
      int j = $urandom_range(15, 0);
      bit t = pat[i];
      pat[i] = pat[j];
      pat[j] = t;
    end
    for (int i = 0; i < 8; i++) begin
      sample_en = hot ? 1'b1 : 1'($urandom);
      set_si(ch, hot ? 1'b1 : 1'($urandom));
      tick();
      if (update !== 1'b0 || busy !== 1'b1) early = 1'b1;
    end
    while (acc < 16 && cyc < 400) begin
      if ($urandom_range(3, 0) == 0) begin
        sample_en = 1'b0;
        set_si(ch, 1'($urandom));
      end else begin
        sample_en = 1'b1;
        set_si(ch, pat[acc]);
        acc++;
      end
      tick();
      cyc++;
      if (update !== 1'b0 || busy !== 1'b1) early = 1'b1;
    end
    sample_en = 1'($urandom);
    set_si(ch, 1'($urandom));
    if (drop) enable = 1'b0;
    tick();
    check("no_early_update", int'(early), 0);
    if (drop) begin
      check("update_suppressed", int'(update), 0);
    end else begin
      check("update_pulse", int'(update), 1);
      check("chan_after", int'(chan), (ch + 1) % 3);
    end
    frac_o = int'(last_frac);
    gain_o = gain_of(ch);
  endtask

  task automatic restart(input int g1, input int g2, input int g3);
    enable = 1'b0;
    tick();
    gain_init_ch1 = 10'(g1);
    gain_init_ch2 = 10'(g2);
    gain_init_ch3 = 10'(g3);
    tick();
    enable = 1'b1;
    tick();
  endtask

  initial begin
    vec_t tbl[12];
    int f, g, mchan, k, ef;
    int mg[3];
    bit early;

    tbl[0]  = '{512,  16, 96, 64, 255, 508};
    tbl[1]  = '{512,   0, 96, 64,   0, 516};
    tbl[2]  = '{512,   5, 96, 64,  80, 512};
    tbl[3]  = '{1022,  0, 96, 64,   0, 1023};
    tbl[4]  = '{2,    16, 96, 64, 255,   0};
    tbl[5]  = '{512,   6, 96, 64,  96, 512};
    tbl[6]  = '{512,   7, 96, 64, 112, 508};
    tbl[7]  = '{512,   4, 96, 64,  64, 512};
    tbl[8]  = '{512,   3, 96, 64,  48, 516};
    tbl[9]  = '{512,   4, 50, 100, 64, 508};
    tbl[10] = '{3,    16, 96, 64, 255,   0};
    tbl[11] = '{1020,  0, 96, 64,   0, 1023};

    reset = 1'b1; enable = 1'b0; sample_en = 1'b0;
    si_ch1 = 2'b00; si_ch2 = 2'b00; si_ch3 = 2'b00;
    thr_hi = 8'd96; thr_lo = 8'd64;
    gain_init_ch1 = 10'd100; gain_init_ch2 = 10'd200; gain_init_ch3 = 10'd300;
    tick();
    tick();
    check("rst_gain1", int'(gain_ch1), 512);
    check("rst_gain2", int'(gain_ch2), 512);
    check("rst_gain3", int'(gain_ch3), 512);
    check("rst_busy", int'(busy), 0);
    check("rst_update", int'(update), 0);
    check("rst_chan", int'(chan), 0);
    check("rst_last_frac", int'(last_frac), 0);
    reset = 1'b0;
    gain_init_ch2 = 10'd300;
    tick();
    check("manual_gain2", int'(gain_ch2), 300);
    check("manual_gain1", int'(gain_ch1), 100);

    foreach (tbl[i]) begin
      thr_hi = 8'(tbl[i].hi);
      thr_lo = 8'(tbl[i].lo);
      restart(tbl[i].init, 700, 800);
      check("vec_busy", int'(busy), 1);
      run_visit(0, tbl[i].k, 1'b0, 1'b0, f, g);
      check("vec_frac", f, tbl[i].efrac);
      check("vec_gain", g, tbl[i].egain);
      check("vec_gain2_untouched", int'(gain_ch2), 700);
      check("vec_gain3_untouched", int'(gain_ch3), 800);
    end

    thr_hi = 8'd96; thr_lo = 8'd64;
    restart(1022, 512, 512);
    run_visit(0, 0, 1'b0, 1'b0, f, g); check("sat_hi_first", g, 1023);
    run_visit(1, 5, 1'b0, 1'b0, f, g);
    run_visit(2, 5, 1'b0, 1'b0, f, g);
    run_visit(0, 0, 1'b0, 1'b0, f, g); check("sat_hi_stays", g, 1023);
    restart(2, 512, 512);
    run_visit(0, 16, 1'b0, 1'b0, f, g); check("sat_lo_first", g, 0);
    run_visit(1, 5, 1'b0, 1'b0, f, g);
    run_visit(2, 5, 1'b0, 1'b0, f, g);
    run_visit(0, 16, 1'b0, 1'b0, f, g); check("sat_lo_stays", g, 0);

    restart(512, 512, 512);
    early = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample_en = 1'($urandom); set_si(0, 1'($urandom)); tick();
      if (update !== 1'b0) early = 1'b1;
    end
    for (int i = 0; i < 32; i++) begin
      sample_en = i[0];
      set_si(0, !i[0]);
      tick();
      if (update !== 1'b0) early = 1'b1;
    end
    sample_en = 1'b0; tick();
    check("toggle_no_early", int'(early), 0);
    check("toggle_update", int'(update), 1);
    check("toggle_frac", int'(last_frac), 0);
    check("toggle_gain", int'(gain_ch1), 516);

    restart(512, 512, 512);
    for (int i = 0; i < 8; i++) begin
      sample_en = 1'b1; set_si(0, 1'b1); tick();
    end
    for (int i = 0; i < 5; i++) begin
      sample_en = 1'b1; set_si(0, 1'b1); tick();
    end
    gain_init_ch1 = 10'd777;
    tick();
    check("run_ignores_init", int'(gain_ch1), 512);
    enable = 1'b0;
    tick();
    check("abort_busy", int'(busy), 0);
    check("abort_update", int'(update), 0);
    check("abort_gain1", int'(gain_ch1), 777);
    check("abort_chan", int'(chan), 0);
    tick();
    check("abort_update_late", int'(update), 0);
    enable = 1'b1;
    tick();
    run_visit(0, 0, 1'b0, 1'b1, f, g);
    check("reenable_frac", f, 0);
    check("reenable_gain", g, 781);

    restart(512, 512, 512);
    run_visit(0, 16, 1'b1, 1'b0, f, g);
    check("decide_drop_busy", int'(busy), 0);
    check("decide_drop_commit", g, 508);
    check("decide_drop_frac", f, 255);
    tick();
    check("decide_drop_track", int'(gain_ch1), 512);
    check("decide_drop_chan", int'(chan), 0);

    restart(100, 100, 100);
    for (int i = 0; i < 3; i++) begin
      sample_en = 1'b1; set_si(0, 1'b1); tick();
    end
    #2 reset = 1'b1;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_gain1", int'(gain_ch1), 512);
    check("async_rst_last_frac", int'(last_frac), 0);
    check("async_rst_update", int'(update), 0);
    tick();
    reset = 1'b0;

    mg[0] = $urandom_range(1023, 0);
    mg[1] = $urandom_range(1023, 0);
    mg[2] = $urandom_range(1023, 0);
    restart(mg[0], mg[1], mg[2]);
    mchan = 0;
    for (int v = 0; v < 24; v++) begin
      thr_hi = 8'($urandom);
      thr_lo = 8'($urandom);
      gain_init_ch1 = 10'($urandom);
      k = $urandom_range(16, 0);
      run_visit(mchan, k, 1'b0, 1'b0, f, g);
      ef = (k * 256) / 16;
      if (ef > 255) ef = 255;
      if (ef > int'(thr_hi)) mg[mchan] = (mg[mchan] < 4) ? 0 : mg[mchan] - 4;
      else if (ef < int'(thr_lo)) mg[mchan] = (mg[mchan] > 1019) ? 1023 : mg[mchan] + 4;
      check("rnd_frac", f, ef);
      for (int c = 0; c < 3; c++) check("rnd_gain", gain_of(c), mg[c]);
      mchan = (mchan + 1) % 3;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
